// File: rtl/scemi_out_pipe_xport.sv
// SCE-MI output pipe endpoint (HW side).
// DUT elements enter through a valid/ready send port and are stored in a FIFO.
// Buffered elements go to the transport link in bursts. A burst starts when
// the threshold is reached, when an end-of-message element is buffered, or
// when a flush is requested. Once started, a burst runs until the FIFO is empty.
module scemi_out_pipe_xport #(
  parameter int BYTES_PER_ELEMENT      = 1,
  parameter int BUFFER_MAX_ELEMENTS    = 8,
  parameter int NOTIFICATION_THRESHOLD = BUFFER_MAX_ELEMENTS
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         send_valid,
  output logic                                         send_ready,
  input  logic [BYTES_PER_ELEMENT*8-1:0]               send_data,
  input  logic                                         send_eom,
  output logic [$clog2(BUFFER_MAX_ELEMENTS+1)-1:0]     can_send,
  input  logic                                         flush_req,
  output logic                                         flush_done,
  output logic                                         tx_valid,
  input  logic                                         tx_ready,
  output logic [BYTES_PER_ELEMENT*8-1:0]               tx_data,
  output logic                                         tx_eom,
  output logic                                         notify
);

  localparam int W     = BYTES_PER_ELEMENT * 8;
  localparam int D     = BUFFER_MAX_ELEMENTS;
  localparam int CW    = $clog2(D + 1);
  localparam int PW    = $clog2(D);
  localparam int THR_I = (NOTIFICATION_THRESHOLD < 1) ? 1 :
                         ((NOTIFICATION_THRESHOLD > D) ? D : NOTIFICATION_THRESHOLD);

  localparam logic [CW-1:0] DEPTH    = CW'(D);
  localparam logic [CW-1:0] THR      = CW'(THR_I);
  localparam logic [PW-1:0] PTR_LAST = PW'(D - 1);

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t        state;
  logic [W:0]    mem [D];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] eom_cnt;
  logic          flush_pend;

  logic          push;
  logic          pop;
  logic          last_pop;
  logic          release_cond;
  logic          start_burst;
  logic          flush_fire;
  logic [W:0]    head;

  // A full FIFO refuses a push even if the head is leaving on the same edge;
  // a pending flush freezes the input so the drain has a fixed end point.
  assign send_ready   = (count != DEPTH) && !flush_pend;
  assign can_send     = DEPTH - count;
  assign push         = send_valid && send_ready;

  // The head entry is read directly. Payload is masked to zero when idle, so
  // nothing stale is shown after reset or between bursts.
  assign head         = mem[rd_ptr];
  assign tx_valid     = (state == DRAIN) && (count != '0);
  assign tx_data      = tx_valid ? head[W-1:0] : '0;
  assign tx_eom       = tx_valid && head[W];
  assign pop          = tx_valid && tx_ready;

  assign release_cond = (count >= THR) || (eom_cnt != '0) || flush_pend;
  assign start_burst  = (state == ACCUM) && release_cond && (count != '0);
  assign last_pop     = pop && !push && (count == CW'(1));
  assign flush_fire   = flush_pend &&
                        (((state == ACCUM) && (count == '0)) ||
                         ((state == DRAIN) && last_pop));

  // Element storage: {eom, data} is written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {send_eom, send_data};
    end
  end

  // Pointers wrap modulo depth; occupancy and the stored-EOM tally follow push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      eom_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      eom_cnt <= eom_cnt + CW'(push && send_eom) - CW'(pop && head[W]);
    end
  end

  // Burst control: accumulate, then drain to empty. Also generates the
  // registered notify/flush_done pulses and tracks the pending flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACCUM;
      notify     <= 1'b0;
      flush_done <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      notify     <= 1'b0;
      flush_done <= flush_fire;
      case (state)
        ACCUM: begin
          if (start_burst) begin
            state  <= DRAIN;
            notify <= 1'b1;
          end
        end
        DRAIN: begin
          if (last_pop) begin
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
      if (flush_fire) begin
        flush_pend <= 1'b0;
      end else if (flush_req) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule
